pixel_adc_sequencer: RTL

- Digital controller for a column of single-slope pixel sensors.
- Drives ERASE, EXPOSE and RAMP to every pixel and samples each pixel's CMP output.
- Converts the ramp pulse count at which CMP trips into a PIXEL_BITS code per pixel, then streams the codes out over a valid/ready interface to the frame buffer.

---
 rtl/pixel_adc_sequencer.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/pixel_adc_sequencer.sv
// ============================================================================
// Module     : pixel_adc_sequencer
// Description: Single-slope pixel column controller: erase, expose, ramp
//              conversion and valid/ready readout of one code per pixel.
//              Optional macro PIXEL_ADC_SEQUENCER_INVERT_EN inverts out_data.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module pixel_adc_sequencer #(
  parameter int PIXEL_COUNT   = 4,
  parameter int PIXEL_BITS    = 8,
  parameter int ERASE_CYCLES  = 4,
  parameter int EXPOSE_CYCLES = 16,
  localparam int IDX_W        = (PIXEL_COUNT > 1) ? $clog2(PIXEL_COUNT) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic                   busy,
  output logic                   ERASE,
  output logic                   EXPOSE,
  output logic                   RAMP,
  input  logic [PIXEL_COUNT-1:0] CMP,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PIXEL_BITS-1:0]  out_data,
  output logic [IDX_W-1:0]       out_index,
  output logic                   out_last
);

  localparam int CODE_MAX = (2 ** PIXEL_BITS) - 1;
  localparam int P_W      = PIXEL_BITS + 1;
  localparam int CNT_MAX  = (ERASE_CYCLES > EXPOSE_CYCLES) ? ERASE_CYCLES : EXPOSE_CYCLES;
  localparam int CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ERASE   = 3'd1,
    S_EXPOSE  = 3'd2,
    S_RAMP_HI = 3'd3,
    S_RAMP_LO = 3'd4,
    S_READOUT = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [P_W-1:0]   p_q, p_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             erase_q, erase_d;
  logic             expose_q, expose_d;
  logic             ramp_q, ramp_d;

  logic [PIXEL_COUNT-1:0] trip_next;
  logic [PIXEL_BITS-1:0]  code_arr [PIXEL_COUNT];
  logic                   all_tripped;
  logic [PIXEL_BITS-1:0]  sel_code;

  assign all_tripped = &trip_next;

  // Per-pixel tripped flag and code latch; ERASE preloads the full-scale code
  // so a pixel that never trips reads out as 2^PIXEL_BITS-1.
  generate
    for (genvar gi = 0; gi < PIXEL_COUNT; gi++) begin : g_pixel
      logic                  trip_q, trip_d;
      logic [PIXEL_BITS-1:0] code_q, code_d;

      always_comb begin
        trip_d = trip_q;
        code_d = code_q;
        if (state_q == S_ERASE) begin
          trip_d = 1'b0;
          code_d = '1;
        end else if (state_q == S_RAMP_LO && CMP[gi] && !trip_q) begin
          trip_d = 1'b1;
          code_d = p_q[PIXEL_BITS-1:0];
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          trip_q <= 1'b0;
          code_q <= '0;
        end else begin
          trip_q <= trip_d;
          code_q <= code_d;
        end
      end

      assign trip_next[gi] = trip_d;
      assign code_arr[gi]  = code_q;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ERASE;
          cnt_d   = '0;
        end
      end
      S_ERASE: begin
        p_d = '0;
        if (cnt_q == CNT_W'(ERASE_CYCLES - 1)) begin
          state_d = S_EXPOSE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_EXPOSE: begin
        if (cnt_q == CNT_W'(EXPOSE_CYCLES - 1)) begin
          state_d = S_RAMP_HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RAMP_HI: begin
        state_d = S_RAMP_LO;
      end
      S_RAMP_LO: begin
        p_d = p_q + 1'b1;
        if (all_tripped || p_q == P_W'(CODE_MAX)) begin
          state_d = S_READOUT;
          idx_d   = '0;
          valid_d = 1'b1;
        end else begin
          state_d = S_RAMP_HI;
        end
      end
      S_READOUT: begin
        if (valid_q && out_ready) begin
          if (idx_q == IDX_W'(PIXEL_COUNT - 1)) begin
            state_d = S_IDLE;
            idx_d   = '0;
            valid_d = 1'b0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        idx_d   = '0;
      end
    endcase

    // Pin drives are registered copies of the next state so they line up
    // exactly with the state they belong to.
    busy_d   = (state_d != S_IDLE);
    erase_d  = (state_d == S_ERASE);
    expose_d = (state_d == S_EXPOSE);
    ramp_d   = (state_d == S_RAMP_HI);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      p_q      <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      erase_q  <= 1'b0;
      expose_q <= 1'b0;
      ramp_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      erase_q  <= erase_d;
      expose_q <= expose_d;
      ramp_q   <= ramp_d;
    end
  end

  always_comb begin
    sel_code = code_arr[idx_q];
`ifdef PIXEL_ADC_SEQUENCER_INVERT_EN
    out_data = valid_q ? (PIXEL_BITS'(CODE_MAX) - sel_code) : '0;
`else
    out_data = valid_q ? sel_code : '0;
`endif
  end

  assign busy      = busy_q;
  assign ERASE     = erase_q;
  assign EXPOSE    = expose_q;
  assign RAMP      = ramp_q;
  assign out_valid = valid_q;
  assign out_index = idx_q;
  assign out_last  = valid_q && (idx_q == IDX_W'(PIXEL_COUNT - 1));

endmodule

`default_nettype wire
